// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared constants, helpers and token type for the TDC thermometer decoder
package tdc_pkg;

    localparam int GROUP_W = 8;

    // Token fields are sized for the widest supported configuration; the
    // decoder narrows them to COARSE_W / FINE_W at its outputs.
    localparam int TOK_COARSE_W = 32;
    localparam int TOK_FINE_W   = 16;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

    function automatic int ngrp(input int nff);
        return (nff + GROUP_W - 1) / GROUP_W;
    endfunction

    // Width of one group count: values 0..GROUP_W.
    localparam int GCNT_W = clog2(GROUP_W + 1);

    typedef struct packed {
        logic                    valid;
        logic [TOK_COARSE_W-1:0] coarse;
        logic [TOK_FINE_W-1:0]   fine;
        logic                    full;
    } tdc_tok_t;

endpackage

// File: rtl/tdc_popcnt_group.sv
// rtl/tdc_popcnt_group.sv - combinational ones-count of one GROUP_W-bit slice
//
// Ports:
//   bits   in  GROUP_W  slice of the (zero-padded) thermometer word
//   count  out GCNT_W   number of ones in bits
module tdc_popcnt_group
    import tdc_pkg::*;
(
    input  logic [GROUP_W-1:0] bits,
    output logic [GCNT_W-1:0]  count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < GROUP_W; i++) begin
            count = count + GCNT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/tdc_thermo_decoder.sv
// rtl/tdc_thermo_decoder.sv - hit detection, pipelined ones-count and timestamp output register
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   therm_in  [NFF]     registered thermometer sample from the delay line
//   arm                 1 = new hits launch into the pipeline
//   ovf_clr             clears the sticky ovf flag (a same-cycle drop wins)
//   ts_ready            downstream accepts the held timestamp
//   ts_valid            timestamp held in the output register
//   ts_coarse [COARSE_W] free-running count at the edge that sampled the hit
//   ts_fine   [FINE_W]  ones-count of the hit sample
//   ts_full             fine == NFF
//   ovf                 sticky: at least one result dropped
//
// Build option: TDC_DEC_BUBBLE_FILTER_EN adds a registered 3-tap majority
// filter ahead of the popcount stage (latency 5 instead of 4).
module tdc_thermo_decoder
    import tdc_pkg::*;
#(
    parameter int NFF      = 200,
    parameter int COARSE_W = 24,
    parameter int FINE_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NFF-1:0]      therm_in,
    input  logic                arm,
    input  logic                ovf_clr,
    input  logic                ts_ready,
    output logic                ts_valid,
    output logic [COARSE_W-1:0] ts_coarse,
    output logic [FINE_W-1:0]   ts_fine,
    output logic                ts_full,
    output logic                ovf
);

    localparam int NGRP  = ngrp(NFF);
    localparam int PAD_W = NGRP * GROUP_W;
    localparam logic [COARSE_W-1:0] CNT_ONE = COARSE_W'(1);

    if ((2 ** FINE_W) <= NFF) begin : g_bad_fine_w
        $error("FINE_W cannot represent a count of NFF");
    end
    if (COARSE_W > TOK_COARSE_W || FINE_W > TOK_FINE_W) begin : g_bad_tok_w
        $error("COARSE_W/FINE_W exceed token field width");
    end

    // S0: sample register, coarse counter and edge detect on tap 0
    logic [COARSE_W-1:0] cnt;
    logic [NFF-1:0]      samp;
    logic [COARSE_W-1:0] samp_coarse;
    logic                samp_vld;
    logic                prev0;
    logic                hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            samp        <= '0;
            samp_coarse <= '0;
            samp_vld    <= 1'b0;
            prev0       <= 1'b1;
        end else begin
            cnt         <= cnt + CNT_ONE;
            samp        <= therm_in;
            samp_coarse <= cnt;
            samp_vld    <= 1'b1;
            // prev0 keeps its reset value of 1 until samp holds a real
            // sample, so a line already high at reset release is no hit.
            if (samp_vld) begin
                prev0 <= samp[0];
            end
        end
    end

    assign hit = arm & samp[0] & ~prev0;

    // Input to the popcount stage, optionally through the bubble filter
    logic                s1_in_vld;
    logic [NFF-1:0]      s1_in_word;
    logic [COARSE_W-1:0] s1_in_coarse;

`ifdef TDC_DEC_BUBBLE_FILTER_EN
    logic [NFF+1:0]      ext;
    logic [NFF-1:0]      filt;
    logic                f_vld;
    logic [NFF-1:0]      f_word;
    logic [COARSE_W-1:0] f_coarse;

    // ext[i+1] = samp[i]; the line is assumed full below tap 0 and empty
    // above the last tap.
    assign ext = {1'b0, samp, 1'b1};

    always_comb begin
        filt = '0;
        for (int i = 0; i < NFF; i++) begin
            filt[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_vld    <= 1'b0;
            f_word   <= '0;
            f_coarse <= '0;
        end else begin
            f_vld    <= hit;
            f_word   <= filt;
            f_coarse <= samp_coarse;
        end
    end

    assign s1_in_vld    = f_vld;
    assign s1_in_word   = f_word;
    assign s1_in_coarse = f_coarse;
`else
    assign s1_in_vld    = hit;
    assign s1_in_word   = samp;
    assign s1_in_coarse = samp_coarse;
`endif

    // S1: per-group popcount, registered
    logic [PAD_W-1:0]               s1_in_pad;
    logic [NGRP-1:0][GCNT_W-1:0]    grp_cnt;
    logic [NGRP-1:0][GCNT_W-1:0]    s1_cnt;
    logic                           s1_vld;
    logic [COARSE_W-1:0]            s1_coarse;

    assign s1_in_pad = PAD_W'(s1_in_word);

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        tdc_popcnt_group u_popcnt (
            .bits  (s1_in_pad[g*GROUP_W +: GROUP_W]),
            .count (grp_cnt[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_cnt    <= '0;
            s1_coarse <= '0;
        end else begin
            s1_vld    <= s1_in_vld;
            s1_cnt    <= grp_cnt;
            s1_coarse <= s1_in_coarse;
        end
    end

    // S2: sum of group counts
    logic [FINE_W-1:0] fine_sum;
    tdc_tok_t          s2_tok;

    always_comb begin
        fine_sum = '0;
        for (int g = 0; g < NGRP; g++) begin
            fine_sum = fine_sum + FINE_W'(s1_cnt[g]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_tok <= '0;
        end else begin
            s2_tok.valid  <= s1_vld;
            s2_tok.coarse <= TOK_COARSE_W'(s1_coarse);
            s2_tok.fine   <= TOK_FINE_W'(fine_sum);
            s2_tok.full   <= (fine_sum == FINE_W'(NFF));
        end
    end

    // Output register: one entry, refilled in the same cycle it drains
    tdc_tok_t out_tok;
    logic     load;
    logic     drop;

    assign load = s2_tok.valid & (~out_tok.valid | ts_ready);
    assign drop = s2_tok.valid & ~load;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_tok <= '0;
            ovf     <= 1'b0;
        end else begin
            if (load) begin
                out_tok <= s2_tok;
            end else if (ts_ready) begin
                out_tok.valid <= 1'b0;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign ts_valid  = out_tok.valid;
    assign ts_coarse = out_tok.coarse[COARSE_W-1:0];
    assign ts_fine   = out_tok.fine[FINE_W-1:0];
    assign ts_full   = out_tok.full;

    // Upper token bits beyond the configured widths are always zero.
    logic tok_unused;
    assign tok_unused = ^{out_tok.coarse, out_tok.fine};

endmodule

// File: tb/tb_tdc_thermo_decoder.sv
// tb/tb_tdc_thermo_decoder.sv - scoreboard bench for tdc_thermo_decoder
module tb_tdc_thermo_decoder;

    localparam int NFF = 200;
    localparam int CW  = 10;
    localparam int FW  = 8;
`ifdef TDC_DEC_BUBBLE_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NFF-1:0] therm_in = '0;
    logic           arm = 1'b0;
    logic           ovf_clr = 1'b0;
    logic           ts_ready = 1'b1;
    logic           ts_valid;
    logic [CW-1:0]  ts_coarse;
    logic [FW-1:0]  ts_fine;
    logic           ts_full;
    logic           ovf;

    always #5 clk = ~clk;

    tdc_thermo_decoder #(.NFF(NFF), .COARSE_W(CW), .FINE_W(FW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .therm_in  (therm_in),
        .arm       (arm),
        .ovf_clr   (ovf_clr),
        .ts_ready  (ts_ready),
        .ts_valid  (ts_valid),
        .ts_coarse (ts_coarse),
        .ts_fine   (ts_fine),
        .ts_full   (ts_full),
        .ovf       (ovf)
    );

    typedef struct {
        logic [CW-1:0] coarse;
        int            fine;
        bit            full;
        int            due;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [CW-1:0] tb_cnt = '0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        tb_cnt <= rst_n ? tb_cnt + 1'b1 : '0;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int fine_model(input logic [NFF-1:0] w);
        logic [NFF-1:0] f;
        logic           lo, hi;
        f = w;
`ifdef TDC_DEC_BUBBLE_FILTER_EN
        for (int i = 0; i < NFF; i++) begin
            lo = (i == 0) ? 1'b1 : w[i-1];
            hi = (i == NFF - 1) ? 1'b0 : w[i+1];
            f[i] = (lo & w[i]) | (lo & hi) | (w[i] & hi);
        end
`endif
        return $countones(f);
    endfunction

    function automatic logic [NFF-1:0] thermo(input int k);
        logic [NFF-1:0] w;
        w = '0;
        for (int i = 0; i < k; i++) w[i] = 1'b1;
        return w;
    endfunction

    // Output monitor: every newly presented timestamp is popped and compared.
    logic prev_v = 1'b0;
    logic prev_r = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (ts_valid && (!prev_v || prev_r)) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("coarse", ts_coarse, mon_e.coarse);
                    check("fine", ts_fine, mon_e.fine);
                    check("full", ts_full, mon_e.full);
                    check("latency", cyc, mon_e.due);
                end
            end
            prev_v = ts_valid;
            prev_r = ts_ready;
        end
    end

    // Drive one hit word for one cycle followed by a zero cycle.
    // exp_coarse < 0 means the expected coarse is the current counter.
    task automatic hit(input logic [NFF-1:0] w, input bit push, input int exp_coarse,
                       output logic [CW-1:0] c_used);
        int f;
        f = fine_model(w);
        c_used = (exp_coarse < 0) ? tb_cnt : CW'(exp_coarse);
        therm_in = w;
        if (push) sb.push_back('{c_used, f, (f == NFF), cyc + LAT});
        @(negedge clk);
        therm_in = '0;
        @(negedge clk);
    endtask

    task automatic wait_cnt(input logic [CW-1:0] v);
        for (int i = 0; i < 3000; i++) begin
            if (tb_cnt == v) return;
            @(negedge clk);
        end
        check("wait_cnt_timeout", tb_cnt, v);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    logic [CW-1:0]  c;
    logic [CW-1:0]  a_coarse;
    logic [NFF-1:0] w;
    int             a_fine;

    initial begin
        therm_in = '1;
        arm      = 1'b1;
        ts_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", ts_valid, 0);
        check("rst_coarse", ts_coarse, 0);
        check("rst_fine", ts_fine, 0);
        check("rst_full", ts_full, 0);
        check("rst_ovf", ovf, 0);

        // Line high across reset release: no hit
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("idle_valid", ts_valid, 0);
        check("idle_ovf", ovf, 0);

        // 37-tap hit at coarse 100
        therm_in = '0;
        wait_cnt(CW'(100));
        hit(thermo(37), 1'b1, 100, c);
        drain();

        // Saturated line
        hit('1, 1'b1, -1, c);
        drain();

        // Random thermometer depths, some back to back (2-cycle spacing)
        for (int i = 0; i < 5; i++) begin
            hit(thermo($urandom_range(1, NFF - 1)), 1'b1, -1, c);
        end
        hit(thermo(1), 1'b1, -1, c);
        hit(thermo(NFF - 1), 1'b1, -1, c);
        drain();

        // Held output and drop
        ts_ready = 1'b0;
        w = thermo(50);
        a_fine = fine_model(w);
        hit(w, 1'b1, -1, a_coarse);
        hit(thermo(90), 1'b0, -1, c);
        repeat (8) @(negedge clk);
        check("hold_valid", ts_valid, 1);
        check("hold_coarse", ts_coarse, a_coarse);
        check("hold_fine", ts_fine, a_fine);
        check("drop_ovf", ovf, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", ovf, 0);

        // Third drop coincides with ovf_clr: set wins
        therm_in = thermo(20);
        @(negedge clk);
        therm_in = '0;
        repeat (LAT - 2) @(negedge clk);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_set_wins", ovf, 1);
        check("hold_coarse2", ts_coarse, a_coarse);
        ts_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("released_valid", ts_valid, 0);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;

        // arm low during hit: ignored
        arm = 1'b0;
        hit(thermo(60), 1'b0, -1, c);
        repeat (8) @(negedge clk);
        check("disarmed_valid", ts_valid, 0);
        // arm dropped right after the launch: token still completes
        arm = 1'b1;
        hit(thermo(61), 1'b1, -1, c);
        arm = 1'b0;
        drain();
        arm = 1'b1;

        // Reset with a token in flight: discarded
        hit(thermo(70), 1'b0, -1, c);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", ts_valid, 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("postrst_valid", ts_valid, 0);
        check("postrst_ovf", ovf, 0);

        // Coarse wrap
        wait_cnt('1);
        hit(thermo(10), 1'b1, (1 << CW) - 1, c);
        repeat (8) @(negedge clk);
        hit(thermo(11), 1'b1, 9, c);
        drain();

        // Bubble word
        w = '0;
        w[9:0] = 10'b0001011111;
        hit(w, 1'b1, -1, c);
        drain();
        check("final_ovf", ovf, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdc_thermo_decoder.md
# tdc_thermo_decoder

Receiving end of the TDC sampling pipeline: consumes the NFF-bit thermometer word registered each `clk` from the tapped delay line and turns each hit into a timestamp. A hit is detected on a 0→1 transition of tap 0 between consecutive samples. The fine value is a pipelined ones-count of the sampled word, paired with a free-running coarse counter. Results are presented through a one-entry valid/ready output register.

## Interface
- `NFF`, 200: delay-line taps / thermometer width.
- `COARSE_W`, 24: coarse counter width.
- `FINE_W`, 8: fine field width; must satisfy 2^FINE_W > NFF (checked at elaboration).
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `therm_in`  in  NFF: registered thermometer sample from the sampling pipeline.
- `arm`  in  1: 1 = hits accepted; 0 = new hits ignored.
- `ovf_clr`  in  1: clears `ovf` sticky flag.
- `ts_ready`  in  1: downstream accepts the timestamp.
- `ts_valid`  out  1: timestamp held.
- `ts_coarse`  out  COARSE_W: coarse count at hit.
- `ts_fine`  out  FINE_W: ones-count of the hit sample (0..NFF).
- `ts_full`  out  1: fine == NFF (line saturated, hit older than one period).
- `ovf`  out  1: sticky, at least one result dropped.

## Operation
- Stage 0 (S0): register `therm_in` as `samp`; keep previous `samp[0]` as `prev0`.
- Hit = `arm & samp[0] & ~prev0`. On hit, launch token into S1 with `samp` and current coarse count.
- S1: per-group popcount, groups of 8 bits (last group zero-padded), registered.
- S2: sum of group counts → fine; `full` = (fine == NFF), registered.
- Output register: loads S2 token when empty or when `ts_valid & ts_ready` in the same cycle; otherwise token is dropped and `ovf` is set.
- Coarse counter: free-running, increments every cycle, wraps modulo 2^COARSE_W without flag.
- `arm` gates only the launch; tokens already in S1/S2 complete.
- `ovf`: set on drop, cleared by `ovf_clr`; set wins on simultaneous set and clear.
- Minimum hit spacing is 2 cycles (tap 0 must return to 0). The pipeline accepts one token per cycle with no internal stall.

## Timing
- Reset (`rst_n`=0 at an edge): `ts_valid`=0, `ts_coarse`=0, `ts_fine`=0, `ts_full`=0, `ovf`=0, coarse counter=0, all pipeline tokens invalid, `samp`=0, `prev0`=1. `prev0`=1 suppresses a spurious hit on the first sample after reset.
- Reset mid-operation: in-flight tokens and the held output are discarded; no output the following cycle.
- Latency: word on `therm_in` at edge N → `samp` at N+1 → `ts_valid`=1 after edge N+4 (S0, S1, S2, output); +1 with the filter option.
- `ts_coarse` is the counter value sampled at the S0 edge that registered the hit word.
- Handshake: output is held stable while `ts_valid & ~ts_ready`; transfer occurs on an edge with both high; `ts_valid` drops the next cycle unless a new token loads.

## Configuration
- `TDC_DEC_BUBBLE_FILTER_EN` defined: insert a registered stage before S1. Each bit is replaced by majority(b[i-1], b[i], b[i+1]), with b[-1]=1 and b[NFF]=0. The coarse value travels with the token. Latency becomes 5.
- Undefined: no filter; the raw ones-count already tolerates bubbles to first order; latency 4.

## Structure
- Package `tdc_pkg`: `GROUP_W`=8, `function clog2`, group-count derivation `NGRP = (NFF+GROUP_W-1)/GROUP_W`, and the token type {valid, coarse, fine, full}.
- Sub-module `tdc_popcnt_group`: GROUP_W-bit input → 4-bit count, combinational, instantiated NGRP times in S1.

## Test plan
- Reset release with `therm_in` all ones → no `ts_valid` ever; `ovf`=0.
- `therm_in` 0 then at coarse=100 word with lowest 37 bits set, `ts_ready`=1 → one `ts_valid` 4 cycles later, `ts_fine`=37, `ts_coarse`=100, `ts_full`=0.
- Hit word all ones (NFF=200) → `ts_fine`=200, `ts_full`=1.
- `ts_ready`=0 and two hits 2 cycles apart → first held unchanged, second dropped, `ovf`=1. Pulse `ovf_clr` together with a third drop → `ovf` stays 1.
- `arm`=0 during a hit → no output; `arm` dropped 1 cycle after a hit → that hit still emerges.
- Coarse at 2^24−1 at hit → `ts_coarse`=0xFFFFFF; next hit 10 cycles later → `ts_coarse`=9. With filter: bubble word 0b…0001011111 → `ts_fine`=6, latency 5.
